// File: rtl/free_list_allocator_if.sv
// Allocation/free handshake between a requester (master) and the free-list
// allocator (slave).
interface free_list_allocator_if #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES)
);
   logic               flush;
   logic               alloc_req;
   logic               alloc_gnt;
   logic [IDX_W-1:0]   alloc_idx;
   logic [ENTRIES-1:0] alloc_oh;
   logic               free_vld;
   logic [IDX_W-1:0]   free_idx;
   logic               free_err;
   logic [IDX_W:0]     free_cnt;
   logic               empty;
   logic               all_free;

   modport master (
      output flush, alloc_req, free_vld, free_idx,
      input  alloc_gnt, alloc_idx, alloc_oh, free_err, free_cnt, empty, all_free
   );

   modport slave (
      input  flush, alloc_req, free_vld, free_idx,
      output alloc_gnt, alloc_idx, alloc_oh, free_err, free_cnt, empty, all_free
   );
endinterface

// File: rtl/free_list_allocator.sv
// Free-list manager: grants the lowest-indexed free entry in the same cycle,
// accepts returns of busy entries, and flags illegal frees one cycle later.
module free_list_allocator #(
   parameter int ENTRIES   = 16,
   parameter int IDX_W     = $clog2(ENTRIES),
   parameter int INIT_BUSY = 0
) (
   input  logic clk,
   input  logic rst,
   free_list_allocator_if.slave fl
);

   function automatic logic [ENTRIES-1:0] init_vec();
      logic [ENTRIES-1:0] v;
      v = '0;
      for (int i = 0; i < INIT_BUSY; i++) v[i] = 1'b1;
      return v;
   endfunction

   localparam logic [ENTRIES-1:0] INIT_BUSY_VEC = init_vec();
   localparam logic [IDX_W:0]     INIT_CNT      = (IDX_W+1)'(ENTRIES - INIT_BUSY);
   localparam logic [IDX_W:0]     FULL_CNT      = (IDX_W+1)'(ENTRIES);

   logic [ENTRIES-1:0] busy_vec;
   logic [ENTRIES-1:0] busy_nxt;
   logic [ENTRIES-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W:0]     free_cnt;
   logic [IDX_W:0]     cnt_nxt;
   logic               free_err;
   logic               gnt;
   logic               legal_free;
   logic               all_below;

   // Lowest-zero priority pick over the current (pre-edge) busy vector.
   always_comb begin
      pick_oh   = '0;
      pick_idx  = '0;
      all_below = 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
         pick_oh[i] = all_below & ~busy_vec[i];
         all_below  = all_below & busy_vec[i];
      end
      for (int i = 0; i < ENTRIES; i++) begin
         if (pick_oh[i]) pick_idx = IDX_W'(i);
      end
   end

   always_comb begin
      gnt        = fl.alloc_req & (free_cnt != '0) & ~fl.flush & ~rst;
      legal_free = 1'b0;
      if (fl.free_vld && ({1'b0, fl.free_idx} < FULL_CNT)) begin
         legal_free = busy_vec[fl.free_idx];
      end
      busy_nxt = busy_vec | (gnt ? pick_oh : '0);
      if (legal_free) busy_nxt[fl.free_idx] = 1'b0;
      cnt_nxt = free_cnt;
      case ({legal_free, gnt})
         2'b10:   cnt_nxt = free_cnt + 1'b1;
         2'b01:   cnt_nxt = free_cnt - 1'b1;
         default: cnt_nxt = free_cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || fl.flush) begin
         busy_vec <= INIT_BUSY_VEC;
         free_cnt <= INIT_CNT;
         free_err <= 1'b0;
      end else begin
         busy_vec <= busy_nxt;
         free_cnt <= cnt_nxt;
         free_err <= fl.free_vld & ~legal_free;
      end
   end

   assign fl.alloc_gnt = gnt;
   assign fl.alloc_idx = pick_idx;
   assign fl.alloc_oh  = gnt ? pick_oh : '0;
   assign fl.free_err  = free_err;
   assign fl.free_cnt  = free_cnt;
   assign fl.empty     = (free_cnt == '0);
   assign fl.all_free  = (free_cnt == FULL_CNT);

endmodule

// File: tb/tb_free_list_allocator.sv
// Bench for free_list_allocator: three configurations checked against a
// reference busy-vector model through an expectation queue.
module tb_free_list_allocator;

   typedef struct {
      int id;
      int cnt;
      bit err;
   } exp_t;

   localparam int NE [3] = '{16, 12, 16};
   localparam int NI [3] = '{0, 0, 4};

   logic clk = 1'b0;
   logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
   always #5 clk = ~clk;

   free_list_allocator_if #(.ENTRIES(16)) ia ();
   free_list_allocator_if #(.ENTRIES(12)) ib ();
   free_list_allocator_if #(.ENTRIES(16)) ic ();

   free_list_allocator #(.ENTRIES(16), .INIT_BUSY(0)) dut_a (.clk(clk), .rst(rst_a), .fl(ia));
   free_list_allocator #(.ENTRIES(12), .INIT_BUSY(0)) dut_b (.clk(clk), .rst(rst_b), .fl(ib));
   free_list_allocator #(.ENTRIES(16), .INIT_BUSY(4)) dut_c (.clk(clk), .rst(rst_c), .fl(ic));

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   logic [15:0] mbusy [3];
   int          mcnt   [3];
   bit          merr   [3];
   bit          mvalid [3] = '{0, 0, 0};

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(int id, bit r, bit f, bit q, bit v, int x);
      case (id)
         0: begin rst_a = r; ia.flush = f; ia.alloc_req = q; ia.free_vld = v; ia.free_idx = 4'(x); end
         1: begin rst_b = r; ib.flush = f; ib.alloc_req = q; ib.free_vld = v; ib.free_idx = 4'(x); end
         default: begin rst_c = r; ic.flush = f; ic.alloc_req = q; ic.free_vld = v; ic.free_idx = 4'(x); end
      endcase
   endtask

   task automatic sample(int id, output logic gnt, output logic [3:0] idx, output logic [15:0] oh,
                         output logic err, output logic [4:0] cnt, output logic emp, output logic af);
      case (id)
         0: begin gnt = ia.alloc_gnt; idx = ia.alloc_idx; oh = ia.alloc_oh; err = ia.free_err;
                  cnt = ia.free_cnt; emp = ia.empty; af = ia.all_free; end
         1: begin gnt = ib.alloc_gnt; idx = ib.alloc_idx; oh = {4'b0, ib.alloc_oh}; err = ib.free_err;
                  cnt = ib.free_cnt; emp = ib.empty; af = ib.all_free; end
         default: begin gnt = ic.alloc_gnt; idx = ic.alloc_idx; oh = ic.alloc_oh; err = ic.free_err;
                  cnt = ic.free_cnt; emp = ic.empty; af = ic.all_free; end
      endcase
   endtask

   // One clock of stimulus: combinational grant checked before the edge,
   // registered state checked from the queue after it.
   task automatic step(int id, bit r, bit f, bit q, bit v, int x);
      logic gnt, err, emp, af;
      logic [3:0]  idx;
      logic [15:0] oh;
      logic [4:0]  cnt;
      int   pick, ne, zeros;
      bit   egnt, legal;
      exp_t e;
      ne = NE[id];
      drive(id, r, f, q, v, x);
      #1;
      pick = -1;
      for (int i = ne - 1; i >= 0; i--) if (!mbusy[id][i]) pick = i;
      egnt = q && mvalid[id] && (mcnt[id] != 0) && (pick >= 0) && !f && !r;
      if (mvalid[id]) begin
         sample(id, gnt, idx, oh, err, cnt, emp, af);
         chk("alloc_gnt", 32'(gnt), 32'(egnt));
         chk("alloc_idx", 32'(idx), (pick < 0) ? 32'd0 : 32'(pick));
         chk("alloc_oh", 32'(oh), egnt ? (32'd1 << pick) : 32'd0);
      end
      if (r || f) begin
         mbusy[id] = '0;
         for (int i = 0; i < NI[id]; i++) mbusy[id][i] = 1'b1;
         mcnt[id]   = ne - NI[id];
         merr[id]   = 1'b0;
         mvalid[id] = 1'b1;
      end else if (mvalid[id]) begin
         legal = v && (x < ne) && mbusy[id][x];
         merr[id] = v && !legal;
         if (egnt) mbusy[id][pick] = 1'b1;
         if (legal) mbusy[id][x] = 1'b0;
         mcnt[id] = mcnt[id] + int'(legal) - int'(egnt);
      end
      if (mvalid[id]) sb.push_back('{id, mcnt[id], merr[id]});
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         sample(e.id, gnt, idx, oh, err, cnt, emp, af);
         zeros = 0;
         for (int i = 0; i < NE[e.id]; i++) if (!mbusy[e.id][i]) zeros++;
         chk("free_cnt", 32'(cnt), 32'(e.cnt));
         chk("free_err", 32'(err), 32'(e.err));
         chk("empty", 32'(emp), 32'(e.cnt == 0));
         chk("all_free", 32'(af), 32'(e.cnt == NE[e.id]));
         chk("invariant", 32'(cnt), 32'(zeros));
      end
   endtask

   initial begin
      drive(0, 1, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0);
      drive(2, 1, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      // Config A: 16 entries, none busy at reset.
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 5);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 3);
      step(0, 0, 0, 1, 1, 9);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 2);
      step(0, 0, 0, 0, 1, 2);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 1, 2);
      for (int n = 0; n < 10000; n++) begin
         step(0, (n == 5000), ($urandom_range(63) == 0), $urandom_range(1) == 1,
              $urandom_range(1) == 1, int'($urandom_range(15)));
      end
      step(0, 0, 0, 0, 0, 0);

      // Config B: 12 entries, out-of-range frees.
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 13);
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 1, 12);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0);

      // Config C: 16 entries, lowest 4 held busy after reset and flush.
      step(2, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(2, 0, 0, 1, 0, 0);
      step(2, 0, 1, 1, 0, 0);
      step(2, 0, 0, 1, 0, 0);
      step(2, 0, 0, 0, 1, 1);
      step(2, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/free_list_allocator.md
Name: free_list_allocator

Overview:
- Sequential free-list manager for a pool of ENTRIES resources, such as physical registers or buffer slots.
- Holds a busy bit vector and grants, on request, the lowest-indexed free entry using a lowest-zero priority pick.
- Accepts frees of previously granted indices and tracks the free count.
- Flags illegal frees and provides a synchronous flush. Sits between a rename/dispatch-style requester and the completion/retire path that returns entries.

Parameters:
- ENTRIES, 16, number of managed entries (>=2, any value, not limited to powers of 2).
- IDX_W, $clog2(ENTRIES), width of entry index.
- INIT_BUSY, 0, number of lowest entries (0..INIT_BUSY-1) held busy after reset/flush; 0 <= INIT_BUSY <= ENTRIES.

Ports:
- Clk_i  input  1  clock, rising edge.
- Rst_i  input  1  synchronous, active-high reset.
- Flush_i  input  1  synchronous return of the pool to its reset state.
- AllocReq_i  input  1  request one entry this cycle.
- AllocGnt_o  output  1  grant; combinational.
- AllocIdx_o  output  IDX_W  granted index; valid when AllocGnt_o=1.
- AllocOH_o  output  ENTRIES  one-hot of granted entry; all zero when no grant.
- FreeVld_i  input  1  return one entry this cycle.
- FreeIdx_i  input  IDX_W  index being returned.
- FreeErr_o  output  1  registered pulse for an illegal free.
- FreeCnt_o  output  IDX_W+1  registered number of free entries.
- Empty_o  output  1  no free entry (FreeCnt_o==0).
- AllFree_o  output  1  FreeCnt_o==ENTRIES.

Behaviour:
- State: BusyVec[ENTRIES-1:0] (1 = allocated), FreeCnt, FreeErr register.
- Reset/flush value:
  - BusyVec bits [INIT_BUSY-1:0]=1, all others 0.
  - FreeCnt=ENTRIES-INIT_BUSY.
  - FreeErr_o=0.
- Reset is synchronous and active-high. Rst_i has priority over Flush_i, and Flush_i has priority over alloc/free.
- Pick:
  - PickOH[0]=~BusyVec[0].
  - PickOH[i]=&BusyVec[i-1:0] & ~BusyVec[i].
  - AllocIdx_o is the binary encode of PickOH, and is 0 when none.
- Grant (same cycle, zero latency):
  - AllocGnt_o = AllocReq_i & ~Empty_o & ~Flush_i & ~Rst_i.
  - AllocOH_o = PickOH when AllocGnt_o, else 0.
  - BusyVec[AllocIdx_o] is set at the next rising edge.
- Free is legal when FreeVld_i=1, FreeIdx_i<ENTRIES and BusyVec[FreeIdx_i]=1 (pre-edge state). A legal free clears that bit at the next edge.
- Illegal free (index >= ENTRIES, or entry already free): no state change. FreeErr_o=1 for exactly one cycle after the offending edge.
- Simultaneous alloc and free, same cycle:
  - Both take effect.
  - The freed entry is NOT visible to this cycle's pick (pick uses current BusyVec). It is allocatable from the next cycle.
  - FreeCnt is unchanged.
- Free of the index being granted the same cycle is illegal by definition, since the bit is 0 pre-edge.
- FreeCnt_next = FreeCnt + legal_free - AllocGnt_o.
  - Never underflows, because a grant requires ~Empty.
  - Never exceeds ENTRIES, because a legal free requires a busy bit.
- Empty_o and AllFree_o decode the registered FreeCnt.
- During Flush_i the grant is suppressed, frees are ignored with no error, and FreeErr_o is cleared.
- Invariant (assert in bench): FreeCnt_o == number of zeros in BusyVec.

Test Plan:
- Reset, ENTRIES=16, INIT_BUSY=0 -> FreeCnt_o=16, AllFree_o=1, Empty_o=0, FreeErr_o=0. Hold AllocReq_i 16 cycles -> AllocIdx_o 0,1,...,15 in order. Next cycle Empty_o=1, AllocGnt_o=0 with request held.
- Full pool, free idx 5 with no alloc -> next cycle FreeCnt_o=1. Alloc -> idx 5 granted, Empty_o=1 again.
- Full pool except idx 3 free, alloc + free idx 9 same cycle -> grant idx 3, FreeCnt_o stays 1. Next alloc grants idx 9.
- Double free of idx 2 (already free) -> FreeErr_o=1 for one cycle, FreeCnt_o unchanged. ENTRIES=12, free idx 13 -> FreeErr_o pulse, no state change.
- INIT_BUSY=4 after reset -> FreeCnt_o=12, first grant idx 4. Allocate 6, then Flush_i -> FreeCnt_o=12, next grant idx 4.
- Random alloc/free for 10k cycles with a scoreboard -> grant is always the lowest free index, no index is granted twice without an intervening free, and the invariant holds. Assert Rst_i mid-stream -> reset values on the next cycle.
